// File: rtl/tt_checker.sv
// Exhaustive truth-table checker: sweeps all 2^K input vectors through a DUT and
// compares its SOP and POS implementations against the canonical outputs.
module tt_checker #(
   parameter int K      = 4,
   parameter int M      = 3,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [K-1:0] vec,
   input  logic [M-1:0] ref_in,
   input  logic [M-1:0] sop_in,
   input  logic [M-1:0] pos_in,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [K:0]   err_count,
   output logic [K-1:0] first_err_vec,
   output logic [M-1:0] first_err_mask,
   output logic         first_err_valid
);

   localparam int           WW   = $clog2(SETTLE + 1);
   localparam logic [K-1:0] LAST = '1;

   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t         state, next_state;
   logic [K-1:0]   n;
   logic [WW-1:0]  wait_cnt;
   logic [M-1:0]   mask;
   logic           mismatch;
   logic           launch;
   logic [K:0]     err_nxt;
   logic           busy_nxt, done_nxt, pass_nxt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   // NOTE: next_state is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE: if (start) next_state = S_APPLY;
         S_APPLY:        next_state = S_SETTLE;
         S_SETTLE:       if (wait_cnt == WW'(1)) next_state = S_SAMPLE;
         S_SAMPLE:       next_state = (n == LAST) ? S_DONE : S_APPLY;
         default:        next_state = S_IDLE;
      endcase
   end

   // Output values are decoded from next_state so the registered flags line
   // up exactly with the state they describe.
   always_comb begin
      mask     = (ref_in ^ sop_in) | (ref_in ^ pos_in);
      mismatch = |mask;
      launch   = (state == S_IDLE || state == S_DONE) && start;
      err_nxt  = err_count;
      if (launch)
         err_nxt = '0;
      else if (state == S_SAMPLE && mismatch)
         err_nxt = err_count + (K+1)'(1);
      busy_nxt = (next_state == S_APPLY) || (next_state == S_SETTLE) ||
                 (next_state == S_SAMPLE);
      done_nxt = (next_state == S_DONE);
      pass_nxt = done_nxt && (err_nxt == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vec             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_vec   <= '0;
         first_err_mask  <= '0;
         first_err_valid <= 1'b0;
         n               <= '0;
         wait_cnt        <= '0;
      end else begin
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         err_count <= err_nxt;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  n               <= '0;
                  first_err_vec   <= '0;
                  first_err_mask  <= '0;
                  first_err_valid <= 1'b0;
               end
            end
            S_APPLY: begin
               vec      <= n;
               wait_cnt <= WW'(SETTLE);
            end
            S_SETTLE: wait_cnt <= wait_cnt - WW'(1);
            S_SAMPLE: begin
               if (mismatch && !first_err_valid) begin
                  first_err_vec   <= n;
                  first_err_mask  <= mask;
                  first_err_valid <= 1'b1;
               end
               // n stops at the last vector; DONE keeps it for inspection.
               if (n != LAST) n <= n + K'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/tt_checker.md
TT_CHECKER -- requirements
Module: tt_checker

Interface
REQ-001 Parameter K, default 4: number of DUT inputs; one sweep applies 2^K vectors.
REQ-002 Parameter M, default 3: number of checked functions; bit 2 = f, bit 1 = g, bit 0 = h.
REQ-003 Parameter SETTLE, default 1, minimum 1: number of wait cycles between applying a vector and sampling.
REQ-004 clk  input  1: single clock; all state changes on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 start  input  1: sweep request, level-sampled.
REQ-007 vec  output  K: vector driven to the DUT, MSB first ({A,B,C,D} for K=4).
REQ-008 ref_in  input  M: canonical outputs of the DUT (f,g,h).
REQ-009 sop_in  input  M: SOP-form outputs of the DUT (fs,gs,hs).
REQ-010 pos_in  input  M: POS-form outputs of the DUT (fp,gp,hp).
REQ-011 busy  output  1: high while a sweep is in progress.
REQ-012 done  output  1: high while the block is in DONE.
REQ-013 pass  output  1: done AND err_count==0.
REQ-014 err_count  output  K+1: number of mismatching vectors in the sweep.
REQ-015 first_err_vec  output  K: lowest vector that mismatched.
REQ-016 first_err_mask  output  M: per-function mismatch bits at first_err_vec.
REQ-017 first_err_valid  output  1: at least one mismatch has been recorded.

Function
REQ-018 States: IDLE, APPLY, SETTLE, SAMPLE, DONE; state and all outputs are registered.
REQ-019 IDLE or DONE with start=1: go to APPLY; set n=0; clear err_count, first_err_*, pass.
REQ-020 start is ignored in APPLY, SETTLE and SAMPLE.
REQ-021 APPLY: vec<=n; go to SETTLE and load the wait counter with SETTLE.
REQ-022 SETTLE: decrement the wait counter each cycle; go to SAMPLE when it reaches 0.
REQ-023 SAMPLE mismatch mask: bit i = (ref_in[i]!=sop_in[i]) OR (ref_in[i]!=pos_in[i]); mismatch when the mask is nonzero.
REQ-024 On mismatch: err_count increments by 1.
REQ-025 On the first mismatch of a sweep only: first_err_vec<=n, first_err_mask<=mask, first_err_valid<=1.
REQ-026 SAMPLE with n==2^K-1: go to DONE; n does not wrap and no extra vector is applied.
REQ-027 SAMPLE otherwise: n<=n+1 and go to APPLY.
REQ-028 Cost per vector is 2+SETTLE cycles; done rises 2^K*(2+SETTLE)+1 cycles after the start edge (49 cycles for defaults).
REQ-029 err_count is never saturated; its maximum value is 2^K.
REQ-030 busy=1 exactly in APPLY, SETTLE and SAMPLE.
REQ-031 DONE holds vec and all results stable until start=1.
REQ-032 start held continuously high: done is high for exactly one cycle, then a new sweep begins.

Reset
REQ-033 reset=0: immediately, without waiting for a clock edge, go to IDLE and force vec, busy, done, pass, err_count, first_err_vec, first_err_mask, first_err_valid and n to 0.
REQ-034 Reset during a sweep aborts it with no partial results retained.
REQ-035 After reset is released, the first sweep starts only on start=1.

Verification
REQ-036 Correct DUT model, defaults, start pulse -> vec steps 0..15, done after 49 cycles, err_count=0, pass=1, first_err_valid=0.
REQ-037 Fault gs inverted at vec=10 only -> err_count=1, first_err_vec=10, first_err_mask=3'b010, pass=0.
REQ-038 Faults at vec=3 (hp) and vec=12 (fs) -> err_count=2, first_err_vec=3, first_err_mask=3'b001.
REQ-039 All functions wrong on every vector -> err_count=16 with no wrap, first_err_vec=0, first_err_mask=3'b111.
REQ-040 reset driven low 20 cycles into a sweep, between clock edges -> all outputs 0 before the next edge; start ignored mid-sweep; a new start gives clean results.
REQ-041 SETTLE=3, start held high -> done high for 1 cycle every 81 cycles; vec stable for 5 cycles per step.
